// File: rtl/ring_osc_ctrl.sv
// ring_osc_ctrl: measures the frequency of a divided ring oscillator by
// counting its rising edges over a gate window of 256..16384 clk cycles.
// Sequence per measurement: IDLE -> WARMUP -> MEASURE -> DONE -> IDLE.
module ring_osc_ctrl #(
    parameter int unsigned COUNT_BITS    = 16,
    parameter int unsigned WARMUP_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            gate_sel,
    input  logic                  osc_clk_div,
    output logic                  osc_en,
    output logic                  busy,
    output logic                  done,
    output logic [COUNT_BITS-1:0] count,
    output logic                  overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WARMUP  = 2'd1,
        MEASURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [7:0]            WARMUP_LAST = 8'(WARMUP_CYCLES - 1);
    localparam logic [COUNT_BITS-1:0] COUNT_MAX   = '1;

    state_t      state;
    logic [1:0]  gate_q;
    logic [7:0]  warm_cnt;
    logic [14:0] win_cnt;
    logic [14:0] win_last;
    logic        sync1;
    logic        sync2;
    logic        sync3;
    logic        edge_pulse;

    // Bring the asynchronous oscillator clock into the clk domain; sync3
    // is one cycle behind sync2 so their difference marks a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
        end else begin
            sync1 <= osc_clk_div;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign edge_pulse = sync2 & ~sync3;

    // Last window-counter value for the latched gate selection (W - 1).
    always_comb begin
        win_last = 15'd255;
        case (gate_q)
            2'd0:    win_last = 15'd255;
            2'd1:    win_last = 15'd1023;
            2'd2:    win_last = 15'd4095;
            default: win_last = 15'd16383;
        endcase
    end

    // Measurement sequencer with registered status outputs and edge counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gate_q   <= '0;
            warm_cnt <= '0;
            win_cnt  <= '0;
            count    <= '0;
            overflow <= 1'b0;
            osc_en   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= WARMUP;
                        gate_q   <= gate_sel;
                        warm_cnt <= '0;
                        osc_en   <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                WARMUP: begin
                    if (abort) begin
                        state    <= IDLE;
                        warm_cnt <= '0;
                        win_cnt  <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        osc_en   <= 1'b0;
                        busy     <= 1'b0;
                    end else if (warm_cnt == WARMUP_LAST) begin
                        state    <= MEASURE;
                        win_cnt  <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                    end else begin
                        warm_cnt <= warm_cnt + 8'd1;
                    end
                end
                MEASURE: begin
                    if (abort) begin
                        state    <= IDLE;
                        warm_cnt <= '0;
                        win_cnt  <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        osc_en   <= 1'b0;
                        busy     <= 1'b0;
                    end else begin
                        // An edge in the final window cycle still counts.
                        if (edge_pulse) begin
                            if (count == COUNT_MAX) begin
                                overflow <= 1'b1;
                            end else begin
                                count <= count + 1'b1;
                            end
                        end
                        if (win_cnt == win_last) begin
                            state  <= DONE;
                            osc_en <= 1'b0;
                            done   <= 1'b1;
                        end else begin
                            win_cnt <= win_cnt + 15'd1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ring_osc_ctrl.sv
// tb_ring_osc_ctrl: randomized and directed checks of ring_osc_ctrl against
// an ideal frequency model (edges = W / period, +-1 for sampling phase).
module tb_ring_osc_ctrl;

    localparam int WARM = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [1:0]  gate_sel;
    logic        osc_clk_div;
    logic        osc_en,   busy,   done,   overflow;
    logic [15:0] count;
    logic        osc_en_s, busy_s, done_s, overflow_s;
    logic [7:0]  count_s;

    int checks   = 0;
    int failures = 0;
    int osc_half = 40;

    ring_osc_ctrl #(.COUNT_BITS(16), .WARMUP_CYCLES(WARM)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .gate_sel(gate_sel), .osc_clk_div(osc_clk_div),
        .osc_en(osc_en), .busy(busy), .done(done),
        .count(count), .overflow(overflow)
    );

    ring_osc_ctrl #(.COUNT_BITS(8), .WARMUP_CYCLES(WARM)) dut_s (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .gate_sel(gate_sel), .osc_clk_div(osc_clk_div),
        .osc_en(osc_en_s), .busy(busy_s), .done(done_s),
        .count(count_s), .overflow(overflow_s)
    );

    always #5 clk = ~clk;

    // Free-running oscillator, phase-offset from clk.
    initial begin
        osc_clk_div = 1'b0;
        #3;
        forever begin
            #(osc_half) osc_clk_div = ~osc_clk_div;
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    // Ideal count within one edge of W/per is accepted; otherwise W/per is demanded.
    function automatic longint tol_exp(input longint got, input int w, input int per);
        longint d;
        d = got * per - w;
        if (d < 0) d = -d;
        return (d <= per) ? got : longint'(w / per);
    endfunction

    task automatic run_meas(input string nm, input int gsel, input int per,
                            input bit noise, input bit chg, input bit both);
        int w, limit, n_en, n_done, done_at, ideal;
        longint cap_cnt, cap_ovf, cap_cnt_s, cap_ovf_s;
        w = 256 << (2 * gsel);
        ideal = w / per;
        osc_half = per * 5;
        repeat (12) @(negedge clk);
        start = 1'b1; gate_sel = 2'(gsel); abort = both;
        n_en = 0; n_done = 0; done_at = 0;
        cap_cnt = 0; cap_ovf = 0; cap_cnt_s = 0; cap_ovf_s = 0;
        limit = WARM + w + 12;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            start = 1'b0; abort = 1'b0;
            if (osc_en) n_en++;
            if (done) begin
                n_done++;
                if (done_at == 0) begin
                    done_at = c;
                    cap_cnt = count; cap_ovf = overflow;
                    cap_cnt_s = count_s; cap_ovf_s = overflow_s;
                    check({nm, "_busy_in_done"}, busy, 1);
                end
            end
            if (c == WARM + w + 2) begin
                check({nm, "_count_held"}, count, cap_cnt);
                check({nm, "_ovf_held"}, overflow, cap_ovf);
            end
            if (chg && c == WARM + 40) gate_sel = gate_sel ^ 2'b11;
            if (noise && (c == 10 || c == WARM + 100 || c == WARM + w + 1)) start = 1'b1;
            if (noise && c == WARM + w + 1) abort = 1'b1;
        end
        check({nm, "_done_at"}, done_at, WARM + w + 1);
        check({nm, "_n_done"}, n_done, 1);
        check({nm, "_osc_en_cycles"}, n_en, WARM + w);
        check({nm, "_count"}, cap_cnt, tol_exp(cap_cnt, w, per));
        check({nm, "_ovf"}, cap_ovf, 0);
        check({nm, "_busy_end"}, busy, 0);
        if (ideal > 256) begin
            check({nm, "_count8"}, cap_cnt_s, 255);
            check({nm, "_ovf8"}, cap_ovf_s, 1);
        end else if (ideal < 254) begin
            check({nm, "_count8"}, cap_cnt_s, tol_exp(cap_cnt_s, w, per));
            check({nm, "_ovf8"}, cap_ovf_s, 0);
        end
    endtask

    // Abort (or reset when use_rst) at MEASURE cycle 100, then watch for stray done.
    task automatic run_cancel(input string nm, input bit use_rst);
        int n_done;
        osc_half = 40;
        repeat (12) @(negedge clk);
        start = 1'b1; gate_sel = 2'd0;
        for (int c = 1; c <= WARM + 100; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        check({nm, "_count_live_nz"}, (count != 0), 1);
        if (use_rst) rst = 1'b1; else abort = 1'b1;
        @(negedge clk);
        rst = 1'b0; abort = 1'b0;
        check({nm, "_osc_en"}, osc_en, 0);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_done"}, done, 0);
        check({nm, "_count"}, count, 0);
        check({nm, "_ovf"}, overflow, 0);
        check({nm, "_count8"}, count_s, 0);
        n_done = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (done || done_s) n_done++;
        end
        check({nm, "_no_done"}, n_done, 0);
    endtask

    initial begin
        longint held;
        rst = 1'b1; start = 1'b0; abort = 1'b0; gate_sel = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_osc_en", osc_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_count", count, 0);
        check("rst_ovf", overflow, 0);
        check("rst_count8", count_s, 0);

        run_meas("basic", 0, 8, 1'b0, 1'b0, 1'b0);

        // abort in IDLE leaves the previous result alone
        held = count;
        abort = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        check("idle_abort_busy", busy, 0);
        check("idle_abort_count", count, held);

        run_meas("noise", 0, 8, 1'b1, 1'b0, 1'b0);
        run_meas("gsel3chg", 3, 8, 1'b0, 1'b1, 1'b0);
        run_meas("sat", 1, 2, 1'b0, 1'b0, 1'b0);
        run_meas("start_abort", 0, 8, 1'b0, 1'b0, 1'b1);

        run_cancel("abort", 1'b0);
        run_meas("after_abort", 0, 8, 1'b0, 1'b0, 1'b0);
        run_cancel("reset", 1'b1);

        // start held continuously: ignored while busy, restarts once IDLE
        repeat (4) @(negedge clk);
        start = 1'b1; gate_sel = 2'd0;
        for (int c = 1; c <= WARM + 259; c++) begin
            @(negedge clk);
            if (c == WARM + 257) check("hold_done", done, 1);
            if (c == WARM + 258) check("hold_idle_busy", busy, 0);
            if (c == WARM + 259) check("hold_restart_busy", busy, 1);
        end
        start = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("hold_abort_busy", busy, 0);

        for (int i = 0; i < 6; i++) begin
            int g, p;
            g = int'($urandom_range(0, 2));
            p = 2 * int'($urandom_range(1, 10));
            run_meas($sformatf("rnd%0d_g%0d_p%0d", i, g, p), g, p, 1'(i % 2), 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
